// File: rtl/s298_bist_ctrl.sv
// -----------------------------------------------------------------------------
// s298_bist_ctrl
//
// Built-in self-test sequencer for one camouflaged s298 core instance. A run
// does four things in order:
//   1. Holds the core in reset.
//   2. Applies pseudo-random patterns from a Galois LFSR to the core inputs.
//   3. Compacts the six core outputs into a Galois MISR.
//   4. Reports the final signature and whether it matches a golden value.
//
// Optional feature macro: S298_BIST_ABORT_EN
//   When it is defined, an extra input port `abort` is added. It ends a run in
//   progress and returns the block to IDLE.
//
// Ports
//   CK            in   clock, rising edge
//   RN            in   synchronous active-low reset
//   start         in   begin a run (accepted in IDLE or DONE only)
//   seed          in   LFSR start value, captured on accepted start
//   num_patterns  in   number of patterns to apply, captured on accepted start
//   golden        in   expected signature, captured on accepted start
//   abort         in   (S298_BIST_ABORT_EN only) abandon the current run
//   core_rst_n    out  drives the core's RN
//   core_in       out  {G2,G1,G0} to the core
//   core_out      in   {G133,G132,G118,G117,G67,G66} from the core
//   busy          out  run in progress
//   done          out  run complete, sticky until the next accepted start
//   pass          out  signature matched golden, valid while done=1
//   signature     out  final MISR value, valid while done=1
//
// Timing
//   Every output is registered. A start sampled at edge 0 raises busy at that
//   same edge. Done and the result are published one edge after the state
//   enters DONE, at edge 1+RST_CYCLES+num_patterns+DRAIN_CYCLES. At that edge
//   busy falls and done rises together, so the two never overlap or gap.
// -----------------------------------------------------------------------------
module s298_bist_ctrl #(
  parameter int unsigned       LFSR_W       = 16,
  parameter int unsigned       MISR_W       = 16,
  parameter int unsigned       CNT_W        = 16,
  parameter logic [LFSR_W-1:0] LFSR_POLY    = LFSR_W'(16'hB400),
  parameter logic [MISR_W-1:0] MISR_POLY    = MISR_W'(16'hB400),
  parameter int unsigned       RST_CYCLES   = 2,
  parameter int unsigned       DRAIN_CYCLES = 1
) (
  input  logic              CK,
  input  logic              RN,
  input  logic              start,
  input  logic [LFSR_W-1:0] seed,
  input  logic [CNT_W-1:0]  num_patterns,
  input  logic [MISR_W-1:0] golden,
`ifdef S298_BIST_ABORT_EN
  input  logic              abort,
`endif
  output logic              core_rst_n,
  output logic [2:0]        core_in,
  input  logic [5:0]        core_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [MISR_W-1:0] signature
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  // Terminal counts for the phase counter. The counter is shared by RST, RUN
  // and DRAIN and restarts from zero at each phase change.
  localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST =
      CNT_W'((DRAIN_CYCLES == 0) ? 0 : DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t              state_q;
  logic [LFSR_W-1:0]   lfsr_q;
  logic [MISR_W-1:0]   misr_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    npat_q;
  logic [MISR_W-1:0]   golden_q;
  logic                busy_q;
  logic                done_q;
  logic                pass_q;
  logic [MISR_W-1:0]   sig_q;
  logic                core_rst_n_q;
  logic [2:0]          core_in_q;

  logic [LFSR_W-1:0]   lfsr_d;
  logic [MISR_W-1:0]   misr_d;
  logic [CNT_W-1:0]    npat_last;

  // One Galois step of each shift register.
  assign lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_POLY : '0);
  assign misr_d = ((misr_q >> 1) ^ (misr_q[0] ? MISR_POLY : '0)) ^ MISR_W'(core_out);

  // RUN is only entered with npat_q != 0, so this never underflows while it
  // is in use. Comparing against N-1 lets N = 2^CNT_W-1 run to completion
  // without the counter wrapping.
  assign npat_last = npat_q - CNT_ONE;

  always_ff @(posedge CK) begin
    if (!RN) begin
      state_q      <= S_IDLE;
      lfsr_q       <= '0;
      misr_q       <= '0;
      cnt_q        <= '0;
      npat_q       <= '0;
      golden_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      sig_q        <= '0;
      core_rst_n_q <= 1'b0;
      core_in_q    <= 3'b000;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          // Publish the result one edge after entering DONE. The MISR is
          // frozen in DONE, so repeating this every cycle is harmless.
          if (state_q == S_DONE) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
            sig_q  <= misr_q;
            pass_q <= (misr_q == golden_q);
          end
          if (start) begin
            // An all-zero seed would lock the LFSR at zero, so it is
            // replaced with 1.
            lfsr_q       <= (seed == '0) ? LFSR_W'(1) : seed;
            npat_q       <= num_patterns;
            golden_q     <= golden;
            misr_q       <= '0;
            cnt_q        <= '0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            busy_q       <= 1'b1;
            core_rst_n_q <= 1'b0;
            core_in_q    <= 3'b000;
            state_q      <= S_RST;
          end
        end

        S_RST: begin
          if (cnt_q == RST_LAST) begin
            cnt_q <= '0;
            if (npat_q != '0) begin
              // The first pattern is the seed itself.
              core_rst_n_q <= 1'b1;
              core_in_q    <= lfsr_q[2:0];
              state_q      <= S_RUN;
            end else begin
              // No patterns: the MISR is still zero from start.
              state_q <= S_DONE;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        S_RUN: begin
          misr_q <= misr_d;
          lfsr_q <= lfsr_d;
          if (cnt_q == npat_last) begin
            cnt_q     <= '0;
            core_in_q <= 3'b000;
            if (DRAIN_CYCLES == 0) begin
              core_rst_n_q <= 1'b0;
              state_q      <= S_DONE;
            end else begin
              state_q <= S_DRAIN;
            end
          end else begin
            cnt_q     <= cnt_q + CNT_ONE;
            core_in_q <= lfsr_d[2:0];
          end
        end

        S_DRAIN: begin
          misr_q <= misr_d;
          if (cnt_q == DRAIN_LAST) begin
            cnt_q        <= '0;
            core_rst_n_q <= 1'b0;
            state_q      <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase

`ifdef S298_BIST_ABORT_EN
      // Abort overrides every transition above while a run is in progress.
      if (abort && (state_q == S_RST || state_q == S_RUN || state_q == S_DRAIN)) begin
        state_q      <= S_IDLE;
        busy_q       <= 1'b0;
        done_q       <= 1'b0;
        cnt_q        <= '0;
        core_rst_n_q <= 1'b0;
        core_in_q    <= 3'b000;
      end
`endif
    end
  end

  assign core_rst_n = core_rst_n_q;
  assign core_in    = core_in_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign signature  = sig_q;

endmodule

// File: tb/tb_s298_bist_ctrl.sv
// -----------------------------------------------------------------------------
// tb_s298_bist_ctrl
//
// Self-checking bench for s298_bist_ctrl with its default parameters. The
// bench plays the role of the s298 core and drives random core_out values.
//
// The reference model works from cycle positions relative to the start edge:
//   - RST occupies RST_CYCLES cycles.
//   - RUN occupies N cycles and presents the successive LFSR values.
//   - DRAIN occupies DRAIN_CYCLES cycles.
//   - The MISR absorbs core_out at the end of every RUN and DRAIN cycle.
//   - done appears one edge after the last absorb.
//
// Define S298_BIST_ABORT_EN to also exercise the abort port.
// -----------------------------------------------------------------------------
module tb_s298_bist_ctrl;

  localparam int RSTC = 2;
  localparam int DRNC = 1;

  logic        CK = 1'b0;
  logic        RN = 1'b0;
  logic        start = 1'b0;
  logic [15:0] seed = '0;
  logic [15:0] num_patterns = '0;
  logic [15:0] golden = '0;
  logic [5:0]  core_out = '0;
  logic        core_rst_n;
  logic [2:0]  core_in;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] signature;
`ifdef S298_BIST_ABORT_EN
  logic        abort = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  always #5 CK = ~CK;

  s298_bist_ctrl dut (
    .CK           (CK),
    .RN           (RN),
    .start        (start),
    .seed         (seed),
    .num_patterns (num_patterns),
    .golden       (golden),
`ifdef S298_BIST_ABORT_EN
    .abort        (abort),
`endif
    .core_rst_n   (core_rst_n),
    .core_in      (core_in),
    .core_out     (core_out),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .signature    (signature)
  );

  // Advance one clock edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic chk(input string tag, input int idx, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s[%0d]: observed=%0h expected=%0h", tag, idx, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic logic [15:0] misr_next(input logic [15:0] v, input logic [5:0] d);
    logic [15:0] s;
    s = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    return s ^ {10'b0, d};
  endfunction

  // One complete run.
  //   out_mode < 0 : core_out is randomised every cycle.
  //   otherwise    : core_out is held at out_mode.
  //   poke_busy    : pulses start mid-run with scrambled inputs; it must be
  //                  ignored.
  // The expected signature is returned in sig.
  task automatic run_bist(input string tag, input logic [15:0] sd, input int n,
                          input logic [15:0] gd, input int out_mode,
                          input bit poke_busy, output logic [15:0] sig);
    logic [15:0] lf;
    logic [15:0] mi;
    int          jend;
    int          poke_at;
    bit          act;
    bit          in_run;
    logic [2:0]  exp_in;

    lf      = (sd == 16'h0) ? 16'h0001 : sd;
    mi      = 16'h0;
    jend    = (n == 0) ? RSTC + 1 : RSTC + n + DRNC + 1;
    poke_at = RSTC + n / 2;

    seed         = sd;
    num_patterns = 16'(n);
    golden       = gd;
    start        = 1'b1;
    tick();                      // edge 0: start accepted
    start        = 1'b0;
    // Scramble the inputs; the captured copies must not be disturbed.
    seed         = 16'($urandom);
    num_patterns = 16'($urandom);
    golden       = 16'($urandom);

    for (int j = 0; j < jend; j++) begin
      core_out = (out_mode < 0) ? 6'($urandom) : 6'(out_mode);
      in_run   = (j >= RSTC) && (j < RSTC + n);
      act      = in_run || ((n > 0) && (j >= RSTC + n) && (j < RSTC + n + DRNC));
      exp_in   = in_run ? lf[2:0] : 3'b000;
      chk({tag, "/core_rst_n"}, j, 32'(core_rst_n), 32'(act));
      chk({tag, "/core_in"},    j, 32'(core_in),    32'(exp_in));
      chk({tag, "/busy"},       j, 32'(busy),       32'd1);
      chk({tag, "/done"},       j, 32'(done),       32'd0);
      if (poke_busy && j == poke_at) start = 1'b1;
      tick();
      start = 1'b0;
      if (act)    mi = misr_next(mi, core_out);
      if (in_run) lf = lfsr_next(lf);
    end

    chk({tag, "/done_end"},   jend, 32'(done),       32'd1);
    chk({tag, "/busy_end"},   jend, 32'(busy),       32'd0);
    chk({tag, "/sig"},        jend, 32'(signature),  32'(mi));
    chk({tag, "/pass"},       jend, 32'(pass),       32'(mi == gd));
    chk({tag, "/rstn_end"},   jend, 32'(core_rst_n), 32'd0);
    tick();
    chk({tag, "/done_hold"},  jend + 1, 32'(done),      32'd1);
    chk({tag, "/sig_hold"},   jend + 1, 32'(signature), 32'(mi));
    sig = mi;
    $display("run %s seed=%04h n=%0d golden=%04h -> sig=%04h pass=%0b",
             tag, sd, n, gd, signature, pass);
  endtask

  initial begin
    logic [15:0] s;

    // Reset
    RN = 1'b0;
    tick();
    tick();
    chk("rst/busy",       0, 32'(busy),       32'd0);
    chk("rst/done",       0, 32'(done),       32'd0);
    chk("rst/pass",       0, 32'(pass),       32'd0);
    chk("rst/signature",  0, 32'(signature),  32'd0);
    chk("rst/core_rst_n", 0, 32'(core_rst_n), 32'd0);
    chk("rst/core_in",    0, 32'(core_in),    32'd0);
    RN = 1'b1;
    tick();
    chk("idle/busy", 0, 32'(busy), 32'd0);
    $display("reset checked");

    // Pattern order: seed 1 gives core_in 001, 000, 000.
    run_bist("order", 16'h0001, 3, 16'h1234, -1, 1'b0, s);

    // Signature with core_out tied high: two absorbs of 6'h3F.
    run_bist("sig3f", 16'h0001, 1, 16'h003F, 6'h3F, 1'b0, s);
    chk("sig3f/value", 0, 32'(signature), 32'(16'h003F ^ 16'hB41F));
    chk("sig3f/pass",  0, 32'(pass),      32'd0);
    run_bist("sig3f_gold", 16'h0001, 1, 16'h003F ^ 16'hB41F, 6'h3F, 1'b0, s);
    chk("sig3f_gold/pass", 0, 32'(pass), 32'd1);

    // Zero patterns
    run_bist("zero_g0", 16'hACE1, 0, 16'h0000, -1, 1'b0, s);
    chk("zero_g0/pass", 0, 32'(pass), 32'd1);
    run_bist("zero_g1", 16'hACE1, 0, 16'h0001, -1, 1'b0, s);
    chk("zero_g1/pass", 0, 32'(pass), 32'd0);

    // start pulsed while busy is ignored; latency is unchanged.
    run_bist("poke", 16'h5A5A, 6, 16'h0000, -1, 1'b1, s);

    // A seed of 0 behaves as seed 1.
    run_bist("seed0", 16'h0000, 4, 16'h0000, -1, 1'b0, s);

    // Random runs, back to back from DONE.
    for (int k = 0; k < 6; k++) begin
      run_bist("rand", 16'($urandom), int'($urandom_range(1, 20)), 16'($urandom),
               -1, 1'($urandom), s);
    end

    // RN low during RUN: reset values next cycle, done never asserted.
    seed         = 16'h1357;
    num_patterns = 16'd8;
    golden       = 16'h0;
    start        = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 0; j < RSTC + 1; j++) tick();
    chk("midrst/in_run", 0, 32'(core_rst_n), 32'd1);
    RN = 1'b0;
    tick();
    chk("midrst/busy",       0, 32'(busy),       32'd0);
    chk("midrst/done",       0, 32'(done),       32'd0);
    chk("midrst/pass",       0, 32'(pass),       32'd0);
    chk("midrst/signature",  0, 32'(signature),  32'd0);
    chk("midrst/core_rst_n", 0, 32'(core_rst_n), 32'd0);
    chk("midrst/core_in",    0, 32'(core_in),    32'd0);
    RN = 1'b1;
    for (int j = 0; j < 15; j++) begin
      tick();
      chk("midrst/no_done", j, 32'(done), 32'd0);
      chk("midrst/no_busy", j, 32'(busy), 32'd0);
    end
    $display("mid-run reset checked");
    run_bist("after_rst", 16'hBEEF, 5, 16'h0000, -1, 1'b0, s);

`ifdef S298_BIST_ABORT_EN
    // Abort in the second RUN cycle.
    seed         = 16'h2468;
    num_patterns = 16'd5;
    golden       = 16'h0;
    start        = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 0; j < RSTC + 1; j++) tick();   // now in second RUN cycle
    chk("abort/in_run", 0, 32'(core_rst_n), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort/busy",       0, 32'(busy),       32'd0);
    chk("abort/done",       0, 32'(done),       32'd0);
    chk("abort/core_rst_n", 0, 32'(core_rst_n), 32'd0);
    for (int j = 0; j < 10; j++) begin
      tick();
      chk("abort/idle_done", j, 32'(done), 32'd0);
      chk("abort/idle_busy", j, 32'(busy), 32'd0);
    end
    $display("abort checked");
    run_bist("after_abort", 16'h1111, 4, 16'h0000, -1, 1'b0, s);
`endif

    // Largest pattern count: the counter must not wrap early.
    run_bist("maxn", 16'($urandom), 65535, 16'($urandom), -1, 1'b0, s);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
